// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: synchronizes the PLL lock flag, holds sys_rst until lock
// has been stable for HOLD_CYCLES, then produces the cpu_ce strobe every CE_DIV
// cycles. Re-asserts sys_rst on lock loss or on req_rst.
// Optional feature macro: PLL_RESET_LOCK_LOSS_COUNT_EN builds the 8-bit
// saturating lock-loss counter; without it lock_loss_cnt is tied to zero.
module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 1200,
    parameter int unsigned CE_DIV      = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       req_rst,
    output logic       sys_rst,
    output logic       cpu_ce,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned DIV_W  = $clog2(CE_DIV + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CE_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   ce_d;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Next-state, counter and strobe decode.
    // The strobe fires on the edge after div_cnt reaches its last value, so the
    // first pulse lands CE_DIV cycles after release; with a one-cycle period
    // every RUN cycle, including the first, is a strobe cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        div_d   = div_q;
        ce_d    = 1'b0;
        unique case (state_q)
            WAIT_LOCK: begin
                hold_d = '0;
                div_d  = '0;
                if (locked_s && !req_rst) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!locked_s || req_rst) begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                    hold_d  = '0;
                    div_d   = '0;
                    ce_d    = (CE_DIV == 1);
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (!locked_s || req_rst) begin
                    state_d = WAIT_LOCK;
                    div_d   = '0;
                end else begin
                    ce_d  = (div_q == DIV_LAST);
                    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                hold_d  = '0;
                div_d   = '0;
            end
        endcase
    end

    // Synchronizer chain, state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= WAIT_LOCK;
            hold_q  <= '0;
            div_q   <= '0;
            sys_rst <= 1'b1;
            cpu_ce  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], locked};
            state_q <= state_d;
            hold_q  <= hold_d;
            div_q   <= div_d;
            sys_rst <= (state_d != RUN);
            cpu_ce  <= ce_d;
        end
    end

`ifdef PLL_RESET_LOCK_LOSS_COUNT_EN
    logic [7:0] loss_q;
    logic       lock_lost;

    // Lock loss in RUN wins over req_rst, so a coincident request counts once.
    assign lock_lost = (state_q == RUN) && !locked_s;

    // Saturating lock-loss counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= 8'h00;
        end else if (lock_lost && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: three instances with different
// parameter sets exercised one after another on a shared clock.
module tb_pll_reset_sequencer;

`ifdef PLL_RESET_LOCK_LOSS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #4 clk = ~clk;

    // dut_a: defaults. dut_b: HOLD 16, CE_DIV 1. dut_c: SYNC 3, HOLD 16, CE_DIV 5.
    logic rst_a = 1'b1, locked_a = 1'b0, req_a = 1'b0, sys_a, ce_a;
    logic rst_b = 1'b1, locked_b = 1'b0, req_b = 1'b0, sys_b, ce_b;
    logic rst_c = 1'b1, locked_c = 1'b0, req_c = 1'b0, sys_c, ce_c;
    logic [7:0] cnt_a, cnt_b, cnt_c;

    pll_reset_sequencer dut_a (
        .clk(clk), .rst(rst_a), .locked(locked_a), .req_rst(req_a),
        .sys_rst(sys_a), .cpu_ce(ce_a), .lock_loss_cnt(cnt_a)
    );

    pll_reset_sequencer #(.SYNC_STAGES(2), .HOLD_CYCLES(16), .CE_DIV(1)) dut_b (
        .clk(clk), .rst(rst_b), .locked(locked_b), .req_rst(req_b),
        .sys_rst(sys_b), .cpu_ce(ce_b), .lock_loss_cnt(cnt_b)
    );

    pll_reset_sequencer #(.SYNC_STAGES(3), .HOLD_CYCLES(16), .CE_DIV(5)) dut_c (
        .clk(clk), .rst(rst_c), .locked(locked_c), .req_rst(req_c),
        .sys_rst(sys_c), .cpu_ce(ce_c), .lock_loss_cnt(cnt_c)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic overlap_seen = 1'b0;

    // cpu_ce must never be high while sys_rst is high on any instance.
    always @(negedge clk) begin
        if ((sys_a && ce_a) || (sys_b && ce_b) || (sys_c && ce_c))
            overlap_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bump(input int v);
        return CNT_EN ? ((v >= 255) ? 255 : v + 1) : 0;
    endfunction

    // Edges until dut_c releases sys_rst; -1 if it never does.
    task automatic release_c(output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (!sys_c) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int e;
        int lat;
        int exp_b;
        int exp_c;

        // ---------------- dut_a: power-up release, defaults ----------------
        repeat (4) tick();
        check("a_reset_sys", sys_a, 1);
        check("a_reset_ce", ce_a, 0);
        check("a_reset_cnt", cnt_a, 0);
        rst_a = 1'b0;
        locked_a = 1'b1;
        e = -1;
        for (int n = 1; n <= 1400; n++) begin
            tick();
            if (!sys_a) begin
                e = n;
                break;
            end
        end
        check("a_release_edge", e, 1203);
        e = -1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (ce_a) begin
                e = n;
                break;
            end
        end
        check("a_first_ce", e, 120);
        for (int p = 0; p < 2; p++) begin
            e = -1;
            for (int n = 1; n <= 300; n++) begin
                tick();
                if (ce_a) begin
                    e = n;
                    break;
                end
            end
            check("a_ce_period", e, 120);
        end
        check("a_cnt_run", cnt_a, 0);
        rst_a = 1'b1;

        // ---------------- dut_b: unstable lock, CE_DIV=1 ----------------
        tick();
        tick();
        rst_b = 1'b0;
        locked_b = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            check("b_hold_first_window", sys_b, 1);
        end
        locked_b = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            check("b_hold_low_window", sys_b, 1);
        end
        locked_b = 1'b1;
        e = -1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (!sys_b) begin
                e = n;
                break;
            end
        end
        check("b_release_edge", e, 19);
        check("b_cnt_unstable", cnt_b, 0);
        check("b_ce_first_run_cycle", ce_b, 1);
        for (int n = 1; n <= 5; n++) begin
            tick();
            check("b_ce_every_cycle", ce_b, 1);
        end
        locked_b = 1'b0;
        tick();
        tick();
        check("b_loss_sys_before", sys_b, 0);
        check("b_loss_ce_before", ce_b, 1);
        tick();
        exp_b = bump(0);
        check("b_loss_sys", sys_b, 1);
        check("b_loss_ce", ce_b, 0);
        check("b_loss_cnt", cnt_b, exp_b);
        tick();
        check("b_ce_in_reset", ce_b, 0);
        rst_b = 1'b1;

        // ---------------- dut_c: loss, request, saturation, reset mid-hold ----------------
        tick();
        rst_c = 1'b0;
        locked_c = 1'b1;
        exp_c = 0;
        release_c(lat);
        check("c_release_edge", lat, 20);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("c_first_ce", ce_c, (k == 5) ? 1 : 0);
        end
        locked_c = 1'b0;
        tick();
        tick();
        tick();
        check("c_loss_sys_before", sys_c, 0);
        check("c_loss_cnt_before", cnt_c, exp_c);
        tick();
        exp_c = bump(exp_c);
        check("c_loss_sys", sys_c, 1);
        check("c_loss_ce", ce_c, 0);
        check("c_loss_cnt", cnt_c, exp_c);

        // req_rst pulse in RUN
        locked_c = 1'b1;
        release_c(lat);
        check("c_relock_release", lat, 20);
        req_c = 1'b1;
        tick();
        req_c = 1'b0;
        check("c_req_sys", sys_c, 1);
        check("c_req_ce", ce_c, 0);
        check("c_req_cnt", cnt_c, exp_c);
        release_c(lat);
        check("c_req_release", lat, 17);

        // req_rst and lock loss seen together
        locked_c = 1'b0;
        tick();
        tick();
        tick();
        req_c = 1'b1;
        tick();
        req_c = 1'b0;
        exp_c = bump(exp_c);
        check("c_both_sys", sys_c, 1);
        check("c_both_cnt", cnt_c, exp_c);
        tick();
        tick();
        check("c_both_cnt_hold", cnt_c, exp_c);

        // Repeated loss: counter saturates
        for (int i = 0; i < 300; i++) begin
            locked_c = 1'b1;
            release_c(lat);
            check("c_sat_release", lat, 20);
            locked_c = 1'b0;
            repeat (4) tick();
            exp_c = bump(exp_c);
        end
        check("c_sat_cnt", cnt_c, exp_c);
        check("c_sat_value", cnt_c, CNT_EN ? 255 : 0);

        // rst while hold_cnt is HOLD_CYCLES/2
        locked_c = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            check("c_midhold_sys", sys_c, 1);
        end
        rst_c = 1'b1;
        tick();
        exp_c = 0;
        check("c_rst_sys", sys_c, 1);
        check("c_rst_ce", ce_c, 0);
        check("c_rst_cnt", cnt_c, 0);
        rst_c = 1'b0;
        release_c(lat);
        check("c_rst_release", lat, 20);
        check("c_rst_cnt_after", cnt_c, exp_c);

        check("ce_sys_overlap", overlap_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sits directly downstream of the system PLL in the clk domain (the PLL's 120 MHz output clock). Synchronizes the PLL `locked` flag, holds the system reset asserted until lock has been stable for a programmable time, and then generates the CPU clock-enable strobe. Re-asserts system reset on loss of lock or on request, and optionally counts lock-loss events.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: depth of the `locked` synchronizer chain; legal range ≥2.
- `HOLD_CYCLES`, default 1200: number of cycles lock must be stable before release (10 µs at 120 MHz); legal range ≥1.
- `CE_DIV`, default 120: `cpu_ce` period in cycles (1 MHz at 120 MHz); legal range ≥1.

Ports:
- `clk` in, 1 bit: PLL output clock. This is the only clock.
- `rst` in, 1 bit: synchronous, active-high reset.
- `locked` in, 1 bit: PLL lock flag. Asynchronous to `clk`.
- `req_rst` in, 1 bit: system reset request. Already synchronous to `clk`, level-sensitive.
- `sys_rst` out, 1 bit: registered system reset, active-high.
- `cpu_ce` out, 1 bit: registered single-cycle clock-enable strobe.
- `lock_loss_cnt` out, 8 bits: saturating count of lock losses while in RUN.

## Operation
- `locked` passes through a chain of SYNC_STAGES flops, all reset to 0. `locked_s` is the last stage.
- FSM states:
  - WAIT_LOCK: if `locked_s`=1 and `req_rst`=0, go to STABLE with `hold_cnt`=0.
  - STABLE: `hold_cnt` increments every cycle. If `locked_s`=0 or `req_rst`=1, return to WAIT_LOCK. When `hold_cnt`=HOLD_CYCLES-1, go to RUN with `div_cnt`=0.
  - RUN:
    - `locked_s`=0: go to WAIT_LOCK and increment `lock_loss_cnt`, saturating at 255.
    - Else `req_rst`=1: go to WAIT_LOCK with no count.
    - If both conditions hold in the same cycle, it is one lock loss and counts once.
- `sys_rst` = 1 in every state except RUN. It is registered and changes on the same edge as the state change.
- `div_cnt` runs 0..CE_DIV-1 in RUN and wraps to 0.
- `cpu_ce` = 1 in exactly the RUN cycles where `div_cnt`=CE_DIV-1. With CE_DIV=1, `cpu_ce` is constantly 1 in RUN.
- `cpu_ce` is 0 whenever `sys_rst` = 1. `cpu_ce` never pulses in the same cycle that `sys_rst` is high.
- Priority: `rst` > lock loss > `req_rst` > normal progression.
- `hold_cnt` is sized from $clog2(HOLD_CYCLES+1). `div_cnt` is sized from $clog2(CE_DIV+1). Neither counter overflows.

## Timing
- Reset values while `rst`=1 and on the edge after it: state WAIT_LOCK, sync chain 0, `hold_cnt`=0, `div_cnt`=0, `sys_rst`=1, `cpu_ce`=0, `lock_loss_cnt`=0.
- Release latency is measured from the first edge that samples `locked`=1 (edge 1), with `locked` held at 1. `sys_rst` falls on edge SYNC_STAGES+1+HOLD_CYCLES (1203 with defaults).
- First `cpu_ce` pulse is CE_DIV cycles after `sys_rst` falls. Pulses then repeat every CE_DIV cycles.
- Lock-loss response:
  - `locked` falls; `locked_s` follows after SYNC_STAGES edges.
  - `sys_rst` rises one edge later and `cpu_ce` is forced to 0 on that edge.
  - `lock_loss_cnt` updates on the same edge.
- `req_rst` response: `sys_rst` rises one edge after `req_rst` is sampled 1. Release needs `req_rst`=0 plus a full new STABLE period.
- `rst` mid-operation: all state returns to reset values on the next edge. The counter is cleared, not frozen.
- `locked` pulses shorter than one `clk` period may be missed. This is acceptable.

## Configuration
- `PLL_RESET_LOCK_LOSS_COUNT_EN` defined: the 8-bit saturating lock-loss counter is built and drives `lock_loss_cnt` as described.
- `PLL_RESET_LOCK_LOSS_COUNT_EN` undefined: no counter register exists and `lock_loss_cnt` is tied to 8'h00. All other behaviour is identical.

## Test plan
- **Power-up release:** defaults; `rst` for 4 cycles, then `locked`=1 held. `sys_rst` falls exactly 1203 edges after the first edge sampling `locked`=1; `cpu_ce` first pulses 120 cycles later, then every 120 cycles.
- **Unstable lock:** HOLD_CYCLES=16; `locked` high for 10 cycles, low for 3, then high. `sys_rst` stays 1 throughout the first window; release occurs SYNC_STAGES+1+16 edges after the final rise; `lock_loss_cnt`=0.
- **Lock loss in RUN:** drop `locked` in RUN. `sys_rst`=1 and `cpu_ce`=0 exactly SYNC_STAGES+1 edges later; `lock_loss_cnt`=1. Repeat 300 times: the count saturates at 255. With the macro undefined, `lock_loss_cnt` is always 0.
- **Request vs loss:** `req_rst` pulse of 1 cycle in RUN re-asserts `sys_rst` next edge with the count unchanged. `req_rst` and lock loss together give a count increment of exactly 1.
- **Reset mid-hold:** assert `rst` while `hold_cnt`=HOLD_CYCLES/2. Next edge shows all reset values; full release latency is restarted.
- **Edge divider:** CE_DIV=1 gives `cpu_ce`=1 on every RUN cycle and 0 while `sys_rst`=1.
